// File: rtl/nco_slot_scheduler_pkg.sv
// Shared types and constants for the NCO slot scheduler and its pitch table.
package nco_slot_scheduler_pkg;

   localparam int unsigned PITCH_W = 24;
   localparam int unsigned VX_W    = 3;
   localparam int unsigned OX_W    = 2;

   typedef struct packed {
      logic [VX_W-1:0] vx;
      logic [OX_W-1:0] ox;
   } slot_idx_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

   function automatic int unsigned slot_count(int unsigned voices, int unsigned v_osc);
      return voices * v_osc;
   endfunction

endpackage

// File: rtl/nco_slot_scheduler_if.sv
// Host-side pitch/sync inputs and NCO-side slot outputs of the scheduler.
interface nco_slot_scheduler_if #(
   parameter int unsigned V_WIDTH = 3,
   parameter int unsigned O_WIDTH = 2
);

   logic                                      iEN;
   logic                                      iPITCH_WE;
   logic [V_WIDTH-1:0]                        iPITCH_VX;
   logic [O_WIDTH-1:0]                        iPITCH_OX;
   logic [nco_slot_scheduler_pkg::PITCH_W-1:0] iPITCH_VAL;
   logic                                      iSYNC_VALID;
   logic [V_WIDTH-1:0]                        iSYNC_VX;
   logic                                      oSYNC_READY;
   logic [V_WIDTH-1:0]                        oVX;
   logic [O_WIDTH-1:0]                        oOX;
   logic [nco_slot_scheduler_pkg::PITCH_W-1:0] oPITCH;
   logic                                      oZERO;
   logic                                      oSLOT_VALID;
   logic                                      oFRAME_START;
   logic                                      oBUSY;

   modport master (
      output iEN, iPITCH_WE, iPITCH_VX, iPITCH_OX, iPITCH_VAL, iSYNC_VALID, iSYNC_VX,
      input  oSYNC_READY, oVX, oOX, oPITCH, oZERO, oSLOT_VALID, oFRAME_START, oBUSY
   );

   modport slave (
      input  iEN, iPITCH_WE, iPITCH_VX, iPITCH_OX, iPITCH_VAL, iSYNC_VALID, iSYNC_VX,
      output oSYNC_READY, oVX, oOX, oPITCH, oZERO, oSLOT_VALID, oFRAME_START, oBUSY
   );

endinterface

// File: rtl/nco_pitch_table.sv
// Per-slot pitch increment storage: one synchronous write port, one combinational read port.
module nco_pitch_table
   import nco_slot_scheduler_pkg::*;
#(
   parameter int unsigned VOICES  = 8,
   parameter int unsigned V_OSC   = 4,
   parameter int unsigned V_WIDTH = 3,
   parameter int unsigned O_WIDTH = 2
) (
   input  logic               OSC_CLK,
   input  logic               reg_reset,
   input  logic               wr_en,
   input  logic [V_WIDTH-1:0] wr_vx,
   input  logic [O_WIDTH-1:0] wr_ox,
   input  logic [PITCH_W-1:0] wr_val,
   input  logic [V_WIDTH-1:0] rd_vx,
   input  logic [O_WIDTH-1:0] rd_ox,
   output logic [PITCH_W-1:0] rd_val
);

   localparam int unsigned DEPTH = slot_count(VOICES, V_OSC);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PITCH_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_addr;
   logic [AW-1:0]      rd_addr;

   assign wr_addr = AW'(wr_vx) * AW'(V_OSC) + AW'(wr_ox);
   assign rd_addr = AW'(rd_vx) * AW'(V_OSC) + AW'(rd_ox);

   // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
   assign rd_val = mem_q[rd_addr];

   always_ff @(posedge OSC_CLK) begin
      if (reg_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_val;
      end
   end

endmodule

// File: rtl/nco_slot_scheduler.sv
// Round-robin slot walker for the NCO accumulator bank, with frame-aligned
// conversion of note-on sync requests into per-voice accumulator-zero flags.
module nco_slot_scheduler
   import nco_slot_scheduler_pkg::*;
#(
   parameter int unsigned VOICES      = 8,
   parameter int unsigned V_OSC       = 4,
   parameter int unsigned V_WIDTH     = 3,
   parameter int unsigned O_WIDTH     = 2,
   parameter int unsigned SLOT_CYCLES = 4
) (
   input logic                 OSC_CLK,
   input logic                 iRST,
   nco_slot_scheduler_if.slave bus
);

   localparam int unsigned PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [PW-1:0]      PRESC_LAST = PW'(SLOT_CYCLES - 1);
   localparam logic [V_WIDTH-1:0] VX_LAST    = V_WIDTH'(VOICES - 1);
   localparam logic [O_WIDTH-1:0] OX_LAST    = O_WIDTH'(V_OSC - 1);

   state_e             st_q, st_d;
   logic [PW-1:0]      presc_q, presc_d;
   slot_idx_t          slot_q, slot_d, slot_nxt, rd_slot;
   logic [PITCH_W-1:0] pitch_q, pitch_d, rd_pitch;
   logic [VOICES-1:0]  pend_q, pend_d;
   logic               zero_q, zero_d;
   logic               valid_q, valid_d;
   logic               fstart_q, fstart_d;
   logic               busy_q;
   logic               ready_q;
   logic               presc_last, frame_last, load, go_idle;

   assign presc_last = (presc_q == PRESC_LAST);
   assign frame_last = (slot_q.vx == VX_LAST) && (slot_q.ox == OX_LAST);

   always_comb begin
      slot_nxt = slot_q;
      if (slot_q.ox == OX_LAST) begin
         slot_nxt.ox = '0;
         slot_nxt.vx = (slot_q.vx == VX_LAST) ? '0 : slot_q.vx + 1'b1;
      end else begin
         slot_nxt.ox = slot_q.ox + 1'b1;
      end
   end

   // Table address for whichever slot is about to be loaded.
   assign rd_slot = (st_q == StIdle) ? '0 : slot_nxt;

   nco_pitch_table #(
      .VOICES  (VOICES),
      .V_OSC   (V_OSC),
      .V_WIDTH (V_WIDTH),
      .O_WIDTH (O_WIDTH)
   ) u_pitch_table (
      .OSC_CLK   (OSC_CLK),
      .reg_reset (iRST),
      .wr_en     (bus.iPITCH_WE),
      .wr_vx     (bus.iPITCH_VX),
      .wr_ox     (bus.iPITCH_OX),
      .wr_val    (bus.iPITCH_VAL),
      .rd_vx     (rd_slot.vx),
      .rd_ox     (rd_slot.ox),
      .rd_val    (rd_pitch)
   );

   always_comb begin
      st_d     = st_q;
      presc_d  = presc_q;
      slot_d   = slot_q;
      pitch_d  = pitch_q;
      zero_d   = zero_q;
      pend_d   = pend_q;
      valid_d  = 1'b0;
      fstart_d = 1'b0;
      load     = 1'b0;
      go_idle  = 1'b0;

      unique case (st_q)
         StIdle: begin
            if (bus.iEN) begin
               st_d   = StRun;
               slot_d = '0;
               load   = 1'b1;
            end
         end
         StRun: begin
            if (!bus.iEN) st_d = StDrain;
            if (presc_last) begin
               slot_d = slot_nxt;
               load   = 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         StDrain: begin
            if (bus.iEN) st_d = StRun;
            if (presc_last && frame_last && !bus.iEN) begin
               st_d    = StIdle;
               go_idle = 1'b1;
            end else if (presc_last) begin
               slot_d = slot_nxt;
               load   = 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: st_d = StIdle;
      endcase

      if (load) begin
         presc_d  = '0;
         valid_d  = 1'b1;
         fstart_d = (slot_d == '0);
         pitch_d  = rd_pitch;
         // Arm once per voice on its first oscillator; held until the voice's last slot ends.
         if (slot_d.ox == '0) begin
            zero_d              = pend_q[slot_d.vx];
            pend_d[slot_d.vx]   = 1'b0;
         end
      end

      if (go_idle) begin
         presc_d = '0;
         slot_d  = '0;
         pitch_d = '0;
         zero_d  = 1'b0;
      end

      // Applied after the consume so a same-cycle request re-arms for the next frame.
      if (bus.iSYNC_VALID && ready_q) pend_d[bus.iSYNC_VX] = 1'b1;
   end

   always_ff @(posedge OSC_CLK) begin
      if (iRST) begin
         st_q     <= StIdle;
         presc_q  <= '0;
         slot_q   <= '0;
         pitch_q  <= '0;
         pend_q   <= '0;
         zero_q   <= 1'b0;
         valid_q  <= 1'b0;
         fstart_q <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         st_q     <= st_d;
         presc_q  <= presc_d;
         slot_q   <= slot_d;
         pitch_q  <= pitch_d;
         pend_q   <= pend_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
         fstart_q <= fstart_d;
         busy_q   <= (st_d != StIdle);
         ready_q  <= 1'b1;
      end
   end

   assign bus.oSYNC_READY  = ready_q;
   assign bus.oVX          = slot_q.vx;
   assign bus.oOX          = slot_q.ox;
   assign bus.oPITCH       = pitch_q;
   assign bus.oZERO        = zero_q;
   assign bus.oSLOT_VALID  = valid_q;
   assign bus.oFRAME_START = fstart_q;
   assign bus.oBUSY        = busy_q;

endmodule

// File: tb/tb_nco_slot_scheduler.sv
// Self-checking bench for nco_slot_scheduler: directed sequences, a pitch-table vector
// table and a randomized run, all checked against a frame-position reference model.
module tb_nco_slot_scheduler;

   localparam int VOICES = 8;
   localparam int V_OSC  = 4;
   localparam int SC     = 4;
   localparam int NSLOT  = VOICES * V_OSC;
   localparam int FRAME  = NSLOT * SC;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nco_slot_scheduler_if #(.V_WIDTH(3), .O_WIDTH(2)) bus ();

   nco_slot_scheduler #(
      .VOICES      (VOICES),
      .V_OSC       (V_OSC),
      .V_WIDTH     (3),
      .O_WIDTH     (2),
      .SLOT_CYCLES (SC)
   ) dut (
      .OSC_CLK (clk),
      .iRST    (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 run, 2 drain; m_pos is the cycle index inside the frame.
   int          m_mode;
   int          m_pos;
   logic [23:0] m_pitch;
   bit          m_zero;
   bit          m_ready;
   bit          m_pend [VOICES];
   logic [23:0] m_tab  [NSLOT];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic model_edge();
      bit entry;
      bit accept;
      int slot;
      int idx;
      if (rst) begin
         m_mode = 0; m_pos = 0; m_pitch = '0; m_zero = 0; m_ready = 0;
         for (int i = 0; i < VOICES; i++) m_pend[i] = 0;
         for (int i = 0; i < NSLOT; i++) m_tab[i] = '0;
         return;
      end
      accept = bus.iSYNC_VALID && m_ready;
      entry  = 0;
      case (m_mode)
         0: if (bus.iEN) begin m_mode = 1; m_pos = 0; entry = 1; end
         1: begin
            if (!bus.iEN) m_mode = 2;
            m_pos = (m_pos + 1) % FRAME;
            entry = (m_pos % SC == 0);
         end
         default: begin
            if (m_pos == FRAME - 1 && !bus.iEN) begin
               m_mode = 0; m_pos = 0; m_pitch = '0; m_zero = 0;
            end else begin
               if (bus.iEN) m_mode = 1;
               m_pos = (m_pos + 1) % FRAME;
               entry = (m_pos % SC == 0);
            end
         end
      endcase
      if (entry) begin
         slot    = m_pos / SC;
         m_pitch = m_tab[slot];
         if (slot % V_OSC == 0) begin
            m_zero = m_pend[slot / V_OSC];
            m_pend[slot / V_OSC] = 0;
         end
      end
      if (accept) m_pend[bus.iSYNC_VX] = 1;
      if (bus.iPITCH_WE) begin
         idx = int'(bus.iPITCH_VX) * V_OSC + int'(bus.iPITCH_OX);
         m_tab[idx] = bus.iPITCH_VAL;
      end
      m_ready = 1;
   endtask

   function automatic logic [33:0] dut_vec();
      return {bus.oSYNC_READY, bus.oBUSY, bus.oFRAME_START, bus.oSLOT_VALID, bus.oZERO,
              bus.oPITCH, bus.oVX, bus.oOX};
   endfunction

   task automatic compare_model();
      logic busy;
      int   slot;
      logic [33:0] exp;
      busy = (m_mode != 0);
      slot = m_pos / SC;
      exp  = {m_ready, busy, busy && (m_pos == 0), busy && (m_pos % SC == 0), m_zero,
              m_pitch, 3'(slot / V_OSC), 2'(slot % V_OSC)};
      check("model", 64'(dut_vec()), 64'(exp));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic clear_inputs();
      bus.iEN = 1'b0; bus.iPITCH_WE = 1'b0; bus.iPITCH_VX = '0; bus.iPITCH_OX = '0;
      bus.iPITCH_VAL = '0; bus.iSYNC_VALID = 1'b0; bus.iSYNC_VX = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic wait_slot(input int v, input int o);
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if (bus.oSLOT_VALID && int'(bus.oVX) == v && int'(bus.oOX) == o) return;
      end
      timeout("wait_slot");
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.oBUSY && n < 3 * FRAME) begin
         step();
         n++;
      end
      if (bus.oBUSY) timeout("wait_idle");
   endtask

   typedef struct {
      int          vx;
      int          ox;
      logic [23:0] val;
   } pw_t;

   pw_t         tbl [4];
   int          n;
   int          p;
   int          slot;
   logic [23:0] exp_pitch;
   logic [6:0]  exp_seq;
   logic        seen;

   initial begin
      tbl[0] = '{3, 2, 24'h012345};
      tbl[1] = '{0, 0, 24'hABCDEF};
      tbl[2] = '{7, 3, 24'hFFFFFF};
      tbl[3] = '{4, 1, 24'h000001};

      // Reset state and free-running slot sequence over two frames.
      do_reset();
      check("reset_state", 64'(dut_vec()), 64'({1'b1, 33'b0}));
      bus.iEN = 1'b1;
      step();
      for (int c = 0; c < 2 * FRAME; c++) begin
         p = c % FRAME;
         exp_seq = {p == 0, p % SC == 0, 3'(p / (SC * V_OSC)), 2'((p / SC) % V_OSC)};
         check("run_seq", 64'({bus.oFRAME_START, bus.oSLOT_VALID, bus.oVX, bus.oOX}),
               64'(exp_seq));
         step();
      end
      bus.iEN = 1'b0;
      wait_idle(n);

      // Pitch table vectors: written while idle, observed over one frame.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.iPITCH_WE = 1'b1; bus.iPITCH_VX = 3'(tbl[i].vx); bus.iPITCH_OX = 2'(tbl[i].ox);
         bus.iPITCH_VAL = tbl[i].val;
         step();
      end
      bus.iPITCH_WE = 1'b0;
      bus.iEN = 1'b1;
      step();
      for (int c = 0; c < FRAME; c++) begin
         slot = c / SC;
         exp_pitch = '0;
         for (int i = 0; i < 4; i++) begin
            if (tbl[i].vx * V_OSC + tbl[i].ox == slot) exp_pitch = tbl[i].val;
         end
         check("pitch_tbl", 64'(bus.oPITCH), 64'(exp_pitch));
         step();
      end
      bus.iEN = 1'b0;
      wait_idle(n);

      // Write landing on the edge that presents (2,1): old value now, new value next frame.
      do_reset();
      bus.iEN = 1'b1;
      wait_slot(2, 0);
      for (int i = 0; i < SC - 1; i++) step();
      bus.iPITCH_WE = 1'b1; bus.iPITCH_VX = 3'd2; bus.iPITCH_OX = 2'd1;
      bus.iPITCH_VAL = 24'h00BEEF;
      step();
      bus.iPITCH_WE = 1'b0;
      check("wr_same_cycle_old", 64'({bus.oVX, bus.oOX, bus.oPITCH}), 64'({3'd2, 2'd1, 24'h0}));
      wait_slot(2, 1);
      check("wr_next_frame_new", 64'(bus.oPITCH), 64'(24'h00BEEF));

      // Sync for voice 5 accepted at (6,0): zeroes exactly (5,*) of the next frame.
      do_reset();
      bus.iEN = 1'b1;
      wait_slot(6, 0);
      bus.iSYNC_VALID = 1'b1; bus.iSYNC_VX = 3'd5;
      step();
      bus.iSYNC_VALID = 1'b0;
      for (p = 6 * V_OSC * SC + 1; p < 3 * FRAME; p++) begin
         check("sync_v5_zero", 64'(bus.oZERO),
               64'((p / FRAME == 1) && ((p % FRAME) / (V_OSC * SC) == 5)));
         step();
      end

      // Voice 1 pending and re-requested on the edge entering (1,0): zeroed twice.
      do_reset();
      bus.iEN = 1'b1;
      wait_slot(2, 0);
      bus.iSYNC_VALID = 1'b1; bus.iSYNC_VX = 3'd1;
      step();
      bus.iSYNC_VALID = 1'b0;
      wait_slot(0, 3);
      for (int i = 0; i < SC - 1; i++) step();
      bus.iSYNC_VALID = 1'b1; bus.iSYNC_VX = 3'd1;
      step();
      bus.iSYNC_VALID = 1'b0;
      check("same_cycle_this", 64'({bus.oVX, bus.oOX, bus.oZERO}), 64'({3'd1, 2'd0, 1'b1}));
      wait_slot(1, 0);
      check("same_cycle_next", 64'(bus.oZERO), 64'(1));
      wait_slot(1, 0);
      check("served_once", 64'(bus.oZERO), 64'(0));

      // Drop iEN at (4,2): the frame completes through (7,3) before going idle.
      do_reset();
      bus.iEN = 1'b1;
      wait_slot(4, 2);
      bus.iEN = 1'b0;
      wait_idle(n);
      check("drain_len", 64'(n), 64'(FRAME - (4 * V_OSC + 2) * SC));

      // Reset mid-frame with voice 7 pending: all outputs clear, no stale zero later.
      do_reset();
      bus.iEN = 1'b1;
      wait_slot(1, 0);
      bus.iSYNC_VALID = 1'b1; bus.iSYNC_VX = 3'd7;
      step();
      bus.iSYNC_VALID = 1'b0;
      wait_slot(2, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_midframe", 64'(dut_vec()), 64'(0));
      seen = 1'b0;
      for (int c = 0; c < 2 * FRAME + SC; c++) begin
         step();
         seen = seen | bus.oZERO;
      end
      check("no_zero_after_rst", 64'(seen), 64'(0));

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 39) == 0) bus.iEN = ~bus.iEN;
         bus.iPITCH_WE   = ($urandom_range(0, 7) == 0);
         bus.iPITCH_VX   = 3'($urandom_range(0, 7));
         bus.iPITCH_OX   = 2'($urandom_range(0, 3));
         bus.iPITCH_VAL  = 24'($urandom);
         bus.iSYNC_VALID = ($urandom_range(0, 9) == 0);
         bus.iSYNC_VX    = 3'($urandom_range(0, 7));
         rst             = ($urandom_range(0, 999) == 0);
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nco_slot_scheduler.md
# nco_slot_scheduler

Time-division scheduler that drives the shared NCO phase-accumulator bank. It walks every voice/oscillator slot in a fixed round-robin order and presents each slot's index and 24-bit pitch increment. It also converts asynchronous per-voice note-on sync requests into frame-aligned accumulator-zero flags. It sits between the host register interface (pitch writes, note events) and the NCO datapath's vx/ox/osc_pitch_val/accum-zero inputs.

## Interface
- VOICES, 8, number of voices
- V_OSC, 4, oscillators per voice
- V_WIDTH, 3, voice index width (clog2 VOICES)
- O_WIDTH, 2, oscillator index width (clog2 V_OSC)
- SLOT_CYCLES, 4, OSC_CLK cycles per slot (≥1)
- OSC_CLK  in  1  single clock
- iRST  in  1  reset; one clock, reset synchronous and active-high
- iEN  in  1  run enable; level
- iPITCH_WE  in  1  pitch table write strobe
- iPITCH_VX  in  V_WIDTH  write voice index
- iPITCH_OX  in  O_WIDTH  write oscillator index
- iPITCH_VAL  in  24  pitch increment to store
- iSYNC_VALID  in  1  note-on sync request
- iSYNC_VX  in  V_WIDTH  voice to sync
- oSYNC_READY  out  1  request accepted when VALID&READY
- oVX  out  V_WIDTH  current slot voice
- oOX  out  O_WIDTH  current slot oscillator
- oPITCH  out  24  pitch increment for current slot
- oZERO  out  1  zero accumulator of current slot
- oSLOT_VALID  out  1  one-cycle pulse, first cycle of each slot
- oFRAME_START  out  1  one-cycle pulse with slot (0,0)
- oBUSY  out  1  state ≠ IDLE

## Operation
- Pitch table: VOICES×V_OSC×24 registers, cleared by iRST. A write takes effect on the next clock edge. A same-cycle read of the written slot returns the old value, so the new value appears the next time that slot is visited.
- Slot order: ox increments fastest, then vx. (0,0),(0,1)…(0,V_OSC-1),(1,0)…(VOICES-1,V_OSC-1), then wrap to (0,0). One full pass is one frame of VOICES·V_OSC·SLOT_CYCLES cycles.
- Prescaler counts 0..SLOT_CYCLES-1. The slot advances when the prescaler wraps.
- FSM states:
  - IDLE: outputs held at reset values. iEN=1 → RUN.
  - RUN: slots advance. iEN=0 → DRAIN.
  - DRAIN: the frame in progress continues. At the end of the last cycle of slot (VOICES-1,V_OSC-1) → IDLE, or → RUN if iEN=1 at that point. iEN returning high during DRAIN re-enters RUN immediately with no gap.
- Sync: oSYNC_READY=1 in every state except reset. An accepted request sets pending[iSYNC_VX]. A duplicate request for an already-pending voice is merged and still acked.
- Zero arming: on entering slot (v,0) with pending[v]=1, latch zero_arm and clear pending[v]. oZERO=zero_arm for slots (v,0..V_OSC-1). zero_arm clears when leaving (v,V_OSC-1). All oscillators of a voice are zeroed in the same frame.
- Simultaneous accept and consume of the same voice: the set wins. pending[v] stays 1 and is served in the next frame, and the current frame still zeroes.
- Pending requests survive IDLE/DRAIN and are served once slots run.

## Timing
- All outputs are registered.
- Reset values: oVX=0, oOX=0, oPITCH=0, oZERO=0, oSLOT_VALID=0, oFRAME_START=0, oBUSY=0. Pending mask, prescaler and table are cleared.
- iEN sampled 1 in IDLE at edge t: at t+1 oBUSY=1, oVX/oOX=(0,0), oSLOT_VALID=1, oFRAME_START=1, and oPITCH=table[0][0].
- oVX/oOX/oPITCH/oZERO change only on slot boundaries and hold for SLOT_CYCLES cycles.
- With SLOT_CYCLES=1, oSLOT_VALID stays high continuously.
- Sync latency: from acceptance to oZERO at most one frame plus V_OSC slots.
- iRST mid-frame: next cycle in IDLE with all reset values. Pending requests are discarded.

## Structure
- Shared package: slot-index struct {vx,ox}, FSM state enum (IDLE, RUN, DRAIN), the 24-bit pitch width constant, and the slot-count function VOICES·V_OSC.
- One sub-module, nco_pitch_table: register file with one synchronous write port and one combinational read port, plus reset clear.
- FSM, prescaler, slot counter and pending/zero logic stay in the top module.

## Test plan
- Reset, then iEN=1 with SLOT_CYCLES=4 → oFRAME_START every 128 cycles, and oSLOT_VALID every 4 cycles with (vx,ox) sequence (0,0),(0,1)…(7,3).
- Write 24'h012345 to (3,2) and then run → oPITCH=24'h012345 only while oVX=3, oOX=2. Other slots show 0.
- Write (2,1) on the cycle slot (2,1) is presented → old value this frame, new value the next frame.
- Sync request for voice 5 accepted mid-frame at slot (6,0) → oZERO=1 for exactly slots (5,0)…(5,3) of the next frame, and 0 everywhere else.
- Sync for voice 1 accepted on the same cycle slot (1,0) is entered with pending[1]=1 → zeroed in both this frame and the next frame.
- Drop iEN at slot (4,2) → frame completes through (7,3), then oBUSY=0. iRST asserted at slot (2,0) with voice 7 pending → all outputs 0 next cycle and no oZERO after restart.
